// File: rtl/enc_stream_sequencer_pkg.sv
// Shared types and defaults for the encryption stream sequencer, its core and its bench.
package enc_pkg;

  localparam int N_DEFAULT          = 8;
  localparam int MAX_BLOCKS_DEFAULT = 16;

  typedef enum logic [1:0] {
    NO_KEY  = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_e;

endpackage

// File: rtl/enc_stream_sequencer_if.sv
// Bus bundle between the sequencer and its environment: key port, input stream,
// core connection, output stream and status.
interface enc_stream_sequencer_if
  import enc_pkg::*;
#(
  parameter int N          = N_DEFAULT,
  parameter int MAX_BLOCKS = MAX_BLOCKS_DEFAULT
);
  localparam int CW = $clog2(MAX_BLOCKS + 1);

  logic [N-1:0]  key_in;
  logic          key_load;
  logic [N-1:0]  s_data;
  logic          s_valid;
  logic          s_ready;
  logic [N-1:0]  enc_data_in;
  logic [N-1:0]  enc_key;
  logic [N-1:0]  enc_data_out;
  logic [N-1:0]  m_data;
  logic          m_valid;
  logic          m_ready;
  logic          key_loaded;
  logic          rekey_req;
  logic [CW-1:0] blk_count;

  // Sequencer side.
  modport slave (
    input  key_in, key_load, s_data, s_valid, enc_data_out, m_ready,
    output s_ready, enc_data_in, enc_key, m_data, m_valid,
           key_loaded, rekey_req, blk_count
  );

  // Environment side (upstream source, core, downstream sink).
  modport master (
    output key_in, key_load, s_data, s_valid, enc_data_out, m_ready,
    input  s_ready, enc_data_in, enc_key, m_data, m_valid,
           key_loaded, rekey_req, blk_count
  );

endinterface

// File: rtl/enc_stream_sequencer.sv
// Key holder, input/output handshake and key-expiry control wrapped around an
// external combinational encryption core.
module enc_stream_sequencer
  import enc_pkg::*;
#(
  parameter int N          = N_DEFAULT,
  parameter int MAX_BLOCKS = MAX_BLOCKS_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  enc_stream_sequencer_if.slave  bus
);
  localparam int CW = $clog2(MAX_BLOCKS + 1);

  state_e        state_q, state_d;
  logic [N-1:0]  key_q, key_d;
  logic [N-1:0]  m_data_q, m_data_d;
  logic          m_valid_q, m_valid_d;
  logic [CW-1:0] blk_count_q, blk_count_d;

  logic          s_ready;
  logic          accept;
  logic          last_block;
  logic          key_loaded;
  logic          rekey_req;

  // Handshake qualifiers: a key_load cycle never accepts, so a word is never
  // encrypted with a key that changes underneath it.
  always_comb begin
    s_ready    = (state_q == RUN) && !bus.key_load && (!m_valid_q || bus.m_ready);
    accept     = bus.s_valid && s_ready;
    last_block = (blk_count_q == CW'(MAX_BLOCKS - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= NO_KEY;
    else     state_q <= state_d;
  end

  // Next-state logic: key_load always lands in RUN; the final permitted accept expires the key.
  always_comb begin
    state_d = state_q;
    if (bus.key_load)              state_d = RUN;
    else if (accept && last_block) state_d = EXPIRED;
  end

  // Status outputs decoded from the state alone.
  always_comb begin
    key_loaded = (state_q == RUN);
    rekey_req  = (state_q == EXPIRED);
  end

  // Datapath next values: key capture, block counting and the 1-entry output stage.
  always_comb begin
    key_d       = key_q;
    blk_count_d = blk_count_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    if (bus.key_load) begin
      key_d       = bus.key_in;
      blk_count_d = '0;
    end else if (accept) begin
      blk_count_d = blk_count_q + CW'(1);
    end
    if (accept) begin
      m_data_d  = bus.enc_data_out;
      m_valid_d = 1'b1;
    end else if (bus.m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // Datapath registers; reset drops any pending output word.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q       <= '0;
      blk_count_q <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
    end else begin
      key_q       <= key_d;
      blk_count_q <= blk_count_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
    end
  end

  assign bus.s_ready     = s_ready;
  assign bus.enc_data_in = bus.s_data;
  assign bus.enc_key     = key_q;
  assign bus.m_data      = m_data_q;
  assign bus.m_valid     = m_valid_q;
  assign bus.key_loaded  = key_loaded;
  assign bus.rekey_req   = rekey_req;
  assign bus.blk_count   = blk_count_q;

endmodule
